uart_tx_cfg: RTL and testbench

Parametrised, runtime-configurable UART transmitter for the serial subsystem. It serialises one character per frame and supports:
- a runtime baud divisor;
- 5–8 data bits;
- none/even/odd parity;
- 1 or 2 stop bits.

Characters are accepted over a valid/ready handshake, so a FIFO can stream frames back-to-back with no idle gap. Output is a registered, glitch-free TX line.

---
 rtl/uart_tx_cfg.sv | 141 ++++++++++++++
 tb/tb_uart_tx_cfg.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 5-8 data bits, none/even/odd parity, 1 or 2 stop bits.
// Format and baud divisor are captured at the handshake, so input changes never disturb a frame in flight.
module uart_tx_cfg #(
  parameter int BAUD_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              SCLK,
  input  logic              RST_n,
  input  logic [BAUD_W-1:0] baud_div,
  input  logic [1:0]        cfg_data_bits,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic [BAUD_W-1:0] BAUD_ONE = {{(BAUD_W-1){1'b0}}, 1'b1};

  state_t            r_state, w_state_nxt;
  logic [BAUD_W-1:0] r_baud_cnt, w_baud_cnt_nxt, r_div;
  logic [2:0]        r_bit_idx, w_bit_idx_nxt, w_last_idx;
  logic              r_stop_idx, w_stop_idx_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic [1:0]        r_nbits, r_par_mode;
  logic              r_stop2, r_par_bit, r_tx;
  logic              w_bit_end, w_last_stop, w_xfer, w_par_en, w_tx_nxt, w_par_bit_in;
  logic [DATA_W-1:0] w_mask, w_data_in;

  // Unused high character bits are cleared so both the shifter and the parity see only N bits.
  assign w_mask       = {DATA_W{1'b1}} >> (2'd3 - cfg_data_bits);
  assign w_data_in    = tx_data & w_mask;
  assign w_par_bit_in = (^w_data_in) ^ (cfg_parity == 2'd2);

  assign w_par_en    = (r_par_mode == 2'd1) || (r_par_mode == 2'd2);
  assign w_last_idx  = 3'd4 + {1'b0, r_nbits};
  assign w_bit_end   = (r_baud_cnt == r_div);
  assign w_last_stop = (r_state == S_STOP) && w_bit_end && (r_stop_idx == r_stop2);

  assign tx_ready = (r_state == S_IDLE) || w_last_stop;
  assign tx_done  = w_last_stop;
  assign tx_busy  = (r_state != S_IDLE);
  assign tx       = r_tx;
  assign w_xfer   = tx_valid && tx_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_bit_idx_nxt  = r_bit_idx;
    w_stop_idx_nxt = r_stop_idx;
    w_shift_nxt    = r_shift;
    w_baud_cnt_nxt = w_bit_end ? '0 : r_baud_cnt + BAUD_ONE;
    w_tx_nxt       = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_baud_cnt_nxt = '0;
        if (w_xfer) w_state_nxt = S_START;
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt   = S_DATA;
          w_bit_idx_nxt = 3'd0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit_idx == w_last_idx) begin
            w_state_nxt    = w_par_en ? S_PARITY : S_STOP;
            w_stop_idx_nxt = 1'b0;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt    = S_STOP;
          w_stop_idx_nxt = 1'b0;
        end
      end
      S_STOP: begin
        if (w_last_stop) w_state_nxt = w_xfer ? S_START : S_IDLE;
        else if (w_bit_end) w_stop_idx_nxt = 1'b1;
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_baud_cnt_nxt = '0;
      end
    endcase
    if (w_xfer) w_shift_nxt = w_data_in;
    // tx is registered from the next state so the start bit appears on the accepting edge.
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
      S_PARITY: w_tx_nxt = r_par_bit;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge SCLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= 3'd0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_div      <= '0;
      r_nbits    <= 2'd0;
      r_par_mode <= 2'd0;
      r_stop2    <= 1'b0;
      r_par_bit  <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_stop_idx <= w_stop_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
      if (w_xfer) begin
        r_div      <= baud_div;
        r_nbits    <= cfg_data_bits;
        r_par_mode <= cfg_parity;
        r_stop2    <= cfg_stop2;
        r_par_bit  <= w_par_bit_in;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: the driver queues a per-bit frame model at each handshake,
// a negedge monitor replays it against tx/tx_busy/tx_done/tx_ready cycle by cycle.
`timescale 1ns/1ps
module tb_uart_tx_cfg;

  logic        SCLK = 1'b0;
  logic        RST_n = 1'b0;
  logic [15:0] baud_div = '0;
  logic [1:0]  cfg_data_bits = '0;
  logic [1:0]  cfg_parity = '0;
  logic        cfg_stop2 = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready, tx, tx_busy, tx_done;

  uart_tx_cfg #(.BAUD_W(16), .DATA_W(8)) dut (
    .SCLK(SCLK), .RST_n(RST_n), .baud_div(baud_div), .cfg_data_bits(cfg_data_bits),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 SCLK = ~SCLK;

  typedef struct {
    logic [11:0] bits;
    int          nbits;
    int          period;
  } frame_t;

  frame_t sb[$];
  int     errors = 0, checks = 0;
  int     pushes = 0, frames_done = 0, aborts_expected = 0;
  bit     active = 0;
  frame_t cur;
  int     bit_i = 0, cyc_i = 0;
  logic [3:0] act, expv;
  logic   last;

  // Frame as a list of line levels: start, N data bits LSB first, optional parity, stop bits.
  function automatic frame_t model(input logic [7:0] d, input logic [1:0] nb, input logic [1:0] par,
                                   input logic s2, input int div);
    frame_t f;
    int n, k, ones;
    n = 5 + int'(nb);
    f.bits = '1;
    k = 0;
    f.bits[k] = 1'b0;
    k++;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      f.bits[k] = d[i];
      ones += int'(d[i]);
      k++;
    end
    if (par == 2'd1) begin
      f.bits[k] = (ones % 2 == 1);
      k++;
    end else if (par == 2'd2) begin
      f.bits[k] = (ones % 2 == 0);
      k++;
    end
    k += s2 ? 2 : 1;
    f.nbits  = k;
    f.period = div + 1;
    return f;
  endfunction

  always @(negedge SCLK) begin
    act = {tx, tx_busy, tx_done, tx_ready};
    if (!RST_n) begin
      checks++;
      if (act !== 4'b1001)
        $display("FAIL reset_state: {tx,busy,done,ready} got %b want 1001", act);
      if (act !== 4'b1001) errors++;
      active = 0;
      sb.delete();
    end else begin
      if (!active && tx === 1'b0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_start: tx got 0 want 1 (no frame queued) at %0t", $time);
        end else begin
          cur    = sb.pop_front();
          active = 1;
          bit_i  = 0;
          cyc_i  = 0;
        end
      end
      if (active) begin
        last = (bit_i == cur.nbits - 1) && (cyc_i == cur.period - 1);
        expv = {cur.bits[bit_i], 1'b1, last, last};
        checks++;
        if (act !== expv) begin
          errors++;
          $display("FAIL frame_cycle bit %0d cyc %0d: {tx,busy,done,ready} got %b want %b at %0t",
                   bit_i, cyc_i, act, expv, $time);
        end
        cyc_i++;
        if (cyc_i == cur.period) begin
          cyc_i = 0;
          bit_i++;
          if (bit_i == cur.nbits) begin
            active = 0;
            frames_done++;
          end
        end
      end else if (tx !== 1'b0) begin
        checks++;
        if (act !== 4'b1001) begin
          errors++;
          $display("FAIL idle_state: {tx,busy,done,ready} got %b want 1001 at %0t", act, $time);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [1:0] nb, input logic [1:0] par,
                      input logic s2, input int div);
    int w;
    w = 0;
    @(negedge SCLK);
    tx_data       = d;
    cfg_data_bits = nb;
    cfg_parity    = par;
    cfg_stop2     = s2;
    baud_div      = div[15:0];
    tx_valid      = 1'b1;
    while (!tx_ready && w < 3000) begin
      @(negedge SCLK);
      w++;
    end
    if (!tx_ready) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: tx_ready got 0 want 1 within 3000 cycles");
      tx_valid = 1'b0;
    end else begin
      sb.push_back(model(d, nb, par, s2, div));
      pushes++;
      @(posedge SCLK);
    end
  endtask

  // Drops valid and scrambles every input; when a frame is running this must not affect it.
  task automatic idle(input int n);
    logic [31:0] r;
    @(negedge SCLK);
    r             = $urandom;
    tx_valid      = 1'b0;
    tx_data       = r[7:0];
    cfg_data_bits = r[9:8];
    cfg_parity    = r[11:10];
    cfg_stop2     = r[12];
    baud_div      = 16'($urandom_range(0, 7));
    repeat (n) @(negedge SCLK);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time got 1ms want bench finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    int w;
    repeat (3) @(posedge SCLK);
    #1 RST_n = 1'b1;
    idle(2);

    send(8'hA5, 2'd3, 2'd0, 1'b0, 3);    // 8N1, 40 cycles
    idle(45);
    send(8'h87, 2'd2, 2'd1, 1'b0, 1);    // 7E1, top bit ignored
    idle(25);
    send(8'hFF, 2'd0, 2'd2, 1'b1, 0);    // 5O2, one cycle per bit
    idle(12);
    send(8'h55, 2'd3, 2'd0, 1'b0, 2);    // back-to-back pair
    send(8'hAA, 2'd3, 2'd0, 1'b0, 2);
    idle(35);

    send(8'h3C, 2'd3, 2'd0, 1'b0, 3);    // reset lands in the data bits
    idle(10);
    @(posedge SCLK);
    #1 RST_n = 1'b0;
    aborts_expected++;
    #1;
    checks++;
    if ({tx, tx_busy, tx_done, tx_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL reset_immediate: {tx,busy,done,ready} got %b want 1001",
               {tx, tx_busy, tx_done, tx_ready});
    end
    repeat (2) @(posedge SCLK);
    #1 RST_n = 1'b1;
    send(8'h96, 2'd3, 2'd1, 1'b0, 2);
    idle(40);

    send(8'h3C, 2'd2, 2'd1, 1'b1, 4);    // config scrambled mid-frame, then a new format
    idle(2);
    send(8'hC3, 2'd0, 2'd2, 1'b0, 1);
    idle(20);

    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      send(r[7:0], r[9:8], r[11:10], r[12], int'($urandom_range(0, 4)));
      if (r[15:14] == 2'd0) idle(int'($urandom_range(0, 15)));
    end
    idle(0);

    w = 0;
    while ((active || sb.size() != 0) && w < 5000) begin
      @(negedge SCLK);
      #1;
      w++;
    end
    checks++;
    if (active || sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: pending frames got %0d want 0", sb.size() + int'(active));
    end
    checks++;
    if (frames_done != pushes - aborts_expected) begin
      errors++;
      $display("FAIL frame_count: completed got %0d want %0d", frames_done, pushes - aborts_expected);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
